// File: rtl/time_keeper.sv
// time_keeper: time-of-day counter driven by the divider's 1 s and 1/4 s waves.
//   clock                 system clock
//   reset                 synchronous, active-low
//   clock_1_second        1 Hz square wave (same-domain register)
//   clock_quarter_second  4 Hz square wave (same-domain register)
//   set_mode              00 RUN, 01 SET_HOURS, 10 SET_MINUTES, 11 FREEZE
//   btn_inc               debounced increment button, 1 = pressed
//   hours/minutes/seconds current time of day
//   second_pulse          1-cycle strobe when seconds advances in RUN
//   blink                 registered quarter-second wave while in a set mode
module time_keeper #(
  parameter int REPEAT_DELAY_Q = 4,
  parameter int HOUR_MAX       = 23
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clock_1_second,
  input  logic       clock_quarter_second,
  input  logic [1:0] set_mode,
  input  logic       btn_inc,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       second_pulse,
  output logic       blink
);

  localparam logic [1:0] MODE_RUN    = 2'b00;
  localparam logic [1:0] MODE_SET_H  = 2'b01;
  localparam logic [1:0] MODE_SET_M  = 2'b10;
  localparam logic [1:0] MODE_FREEZE = 2'b11;

  localparam int RW = (REPEAT_DELAY_Q > 1) ? $clog2(REPEAT_DELAY_Q) : 1;
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_DELAY_Q - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_REPEAT} btn_state_t;

  btn_state_t      state_q, state_d;
  logic [RW-1:0]   rpt_cnt;
  logic            rpt_clr, rpt_inc;
  logic            prev_1s, prev_q, prev_btn;
  logic            tick_1s, tick_q, inc_event;

  // Inputs are already registered in this domain: one history flop per wave.
  assign tick_1s = clock_1_second & ~prev_1s;
  assign tick_q  = clock_quarter_second & ~prev_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_1s  <= 1'b0;
      prev_q   <= 1'b0;
      prev_btn <= 1'b0;
    end else begin
      prev_1s  <= clock_1_second;
      prev_q   <= clock_quarter_second;
      prev_btn <= btn_inc;
    end
  end

  // Button FSM: state register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rpt_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (rpt_clr)      rpt_cnt <= '0;
      else if (rpt_inc) rpt_cnt <= rpt_cnt + 1'b1;
    end
  end

  // Button FSM: next state. Release wins over a coincident tick_q.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (btn_inc && !prev_btn) state_d = ST_WAIT;
      ST_WAIT: begin
        if (!btn_inc)                         state_d = ST_IDLE;
        else if (tick_q && rpt_cnt == RPT_LAST) state_d = ST_REPEAT;
      end
      ST_REPEAT: if (!btn_inc) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Button FSM: outputs (at most one inc_event per cycle)
  always_comb begin
    inc_event = 1'b0;
    rpt_clr   = 1'b0;
    rpt_inc   = 1'b0;
    case (state_q)
      ST_IDLE: if (btn_inc && !prev_btn) begin
        inc_event = 1'b1;
        rpt_clr   = 1'b1;
      end
      ST_WAIT: if (btn_inc && tick_q) begin
        rpt_inc = 1'b1;
        if (rpt_cnt == RPT_LAST) inc_event = 1'b1;
      end
      ST_REPEAT: if (btn_inc && tick_q) inc_event = 1'b1;
      default: ;
    endcase
  end

  // Time counters; the mode is taken fresh every cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hours        <= '0;
      minutes      <= '0;
      seconds      <= '0;
      second_pulse <= 1'b0;
      blink        <= 1'b0;
    end else begin
      second_pulse <= 1'b0;
      blink        <= ((set_mode == MODE_SET_H) || (set_mode == MODE_SET_M)) &
                      clock_quarter_second;
      case (set_mode)
        MODE_RUN: if (tick_1s) begin
          second_pulse <= 1'b1;
          if (seconds == 6'd59) begin
            seconds <= '0;
            if (minutes == 6'd59) begin
              minutes <= '0;
              hours   <= (hours == 5'(HOUR_MAX)) ? 5'd0 : hours + 5'd1;
            end else begin
              minutes <= minutes + 6'd1;
            end
          end else begin
            seconds <= seconds + 6'd1;
          end
        end
        MODE_SET_H: begin
          seconds <= '0;
          if (inc_event) hours <= (hours == 5'(HOUR_MAX)) ? 5'd0 : hours + 5'd1;
        end
        MODE_SET_M: begin
          seconds <= '0;
          if (inc_event) minutes <= (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
        end
        MODE_FREEZE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_time_keeper.sv
module tb_time_keeper;
  logic       clock = 1'b0;
  logic       reset;
  logic       clock_1_second, clock_quarter_second, btn_inc;
  logic [1:0] set_mode;
  logic [4:0] hours;
  logic [5:0] minutes, seconds;
  logic       second_pulse, blink;

  int n_checks = 0;
  int n_fail   = 0;
  logic cap_sp, cap_bl;

  time_keeper #(.REPEAT_DELAY_Q(4), .HOUR_MAX(23)) dut (
    .clock(clock), .reset(reset),
    .clock_1_second(clock_1_second), .clock_quarter_second(clock_quarter_second),
    .set_mode(set_mode), .btn_inc(btn_inc),
    .hours(hours), .minutes(minutes), .seconds(seconds),
    .second_pulse(second_pulse), .blink(blink)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] mode;
    logic       btn, c1, cq;
    int         h, m, s;
    logic       sp, bl;
  } vec_t;

  vec_t tbl[16];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_time(input string name, input int h, input int m, input int s);
    chk({name, ".hours"},   int'(hours),   h);
    chk({name, ".minutes"}, int'(minutes), m);
    chk({name, ".seconds"}, int'(seconds), s);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clock_1_second = 1'b0; clock_quarter_second = 1'b0;
    btn_inc = 1'b0; set_mode = 2'b00;
    step();
    reset = 1'b1;
  endtask

  task automatic press();
    btn_inc = 1'b1; step();
    btn_inc = 1'b0; step();
  endtask

  // One 1 s rising edge; captures the strobe in the cycle it is visible.
  task automatic tick_s();
    clock_1_second = 1'b1; step();
    cap_sp = second_pulse; cap_bl = blink;
    clock_1_second = 1'b0; step();
  endtask

  task automatic tick_qs();
    clock_quarter_second = 1'b1; step();
    clock_quarter_second = 1'b0; step();
  endtask

  initial begin
    // mode btn c1 cq | h m s sp bl
    tbl[0]  = '{2'd0, 1'b0, 1'b1, 1'b0, 0, 0, 1, 1'b1, 1'b0};
    tbl[1]  = '{2'd0, 1'b0, 1'b1, 1'b0, 0, 0, 1, 1'b0, 1'b0};
    tbl[2]  = '{2'd0, 1'b0, 1'b0, 1'b0, 0, 0, 1, 1'b0, 1'b0};
    tbl[3]  = '{2'd0, 1'b0, 1'b1, 1'b0, 0, 0, 2, 1'b1, 1'b0};
    tbl[4]  = '{2'd3, 1'b0, 1'b0, 1'b0, 0, 0, 2, 1'b0, 1'b0};
    tbl[5]  = '{2'd3, 1'b0, 1'b1, 1'b0, 0, 0, 2, 1'b0, 1'b0};
    tbl[6]  = '{2'd0, 1'b0, 1'b0, 1'b0, 0, 0, 2, 1'b0, 1'b0};
    tbl[7]  = '{2'd0, 1'b0, 1'b1, 1'b0, 0, 0, 3, 1'b1, 1'b0};
    tbl[8]  = '{2'd2, 1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b1};
    tbl[9]  = '{2'd2, 1'b1, 1'b0, 1'b1, 0, 1, 0, 1'b0, 1'b1};
    tbl[10] = '{2'd2, 1'b1, 1'b0, 1'b0, 0, 1, 0, 1'b0, 1'b0};
    tbl[11] = '{2'd2, 1'b0, 1'b1, 1'b0, 0, 1, 0, 1'b0, 1'b0};
    tbl[12] = '{2'd1, 1'b1, 1'b0, 1'b1, 1, 1, 0, 1'b0, 1'b1};
    tbl[13] = '{2'd1, 1'b0, 1'b0, 1'b0, 1, 1, 0, 1'b0, 1'b0};
    tbl[14] = '{2'd0, 1'b1, 1'b0, 1'b0, 1, 1, 0, 1'b0, 1'b0};
    tbl[15] = '{2'd0, 1'b0, 1'b1, 1'b0, 1, 1, 1, 1'b1, 1'b0};

    // Reset held with toggling waves
    reset = 1'b0; set_mode = 2'b01; btn_inc = 1'b1;
    clock_1_second = 1'b0; clock_quarter_second = 1'b0;
    for (int i = 0; i < 3; i++) begin
      clock_1_second = ~clock_1_second;
      clock_quarter_second = ~clock_quarter_second;
      step();
      chk_time("rst_hold", 0, 0, 0);
      chk("rst_hold.pulse", int'(second_pulse), 0);
      chk("rst_hold.blink", int'(blink), 0);
    end
    do_reset();
    tick_s();
    chk("rst_rel.pulse", int'(cap_sp), 1);
    chk_time("rst_rel", 0, 0, 1);
    chk("rst_rel.pulse_end", int'(second_pulse), 0);

    // Cycle-by-cycle vector table
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_mode = tbl[i].mode; btn_inc = tbl[i].btn;
      clock_1_second = tbl[i].c1; clock_quarter_second = tbl[i].cq;
      step();
      chk($sformatf("vec%0d.h", i),  int'(hours),        tbl[i].h);
      chk($sformatf("vec%0d.m", i),  int'(minutes),      tbl[i].m);
      chk($sformatf("vec%0d.s", i),  int'(seconds),      tbl[i].s);
      chk($sformatf("vec%0d.sp", i), int'(second_pulse), int'(tbl[i].sp));
      chk($sformatf("vec%0d.bl", i), int'(blink),        int'(tbl[i].bl));
    end

    // Midnight rollover from 23:59:59
    do_reset();
    set_mode = 2'b01; repeat (23) press();
    set_mode = 2'b10; repeat (59) press();
    set_mode = 2'b00; repeat (59) tick_s();
    chk_time("preload", 23, 59, 59);
    clock_1_second = 1'b1; step();
    chk_time("midnight", 0, 0, 0);
    chk("midnight.pulse", int'(second_pulse), 1);
    clock_1_second = 1'b0; step();
    chk("midnight.pulse_end", int'(second_pulse), 0);

    // SET_MINUTES wrap without carry, tick ignored
    tick_s();
    chk_time("pre_set", 0, 0, 1);
    set_mode = 2'b01; repeat (5) press();
    set_mode = 2'b10; step();
    chk_time("setm_entry", 5, 0, 0);
    repeat (59) press();
    chk_time("setm_59", 5, 59, 0);
    press();
    chk_time("setm_wrap", 5, 0, 0);
    tick_s();
    chk("setm_tick.pulse", int'(cap_sp), 0);
    chk_time("setm_tick", 5, 0, 0);

    // Hold-to-repeat in SET_HOURS: press + repeats on tick_q 4,5,6
    set_mode = 2'b01; repeat (19) press();
    chk("seth_zero", int'(hours), 0);
    btn_inc = 1'b1; step();
    chk("hold_press", int'(hours), 1);
    repeat (3) tick_qs();
    chk("hold_wait", int'(hours), 1);
    repeat (3) tick_qs();
    chk("hold_repeat", int'(hours), 4);
    btn_inc = 1'b0; step();
    tick_qs();
    chk("hold_release", int'(hours), 4);

    // FREEZE with button held and waves running
    set_mode = 2'b11; btn_inc = 1'b1; step();
    for (int i = 0; i < 3; i++) begin
      clock_quarter_second = 1'b1;
      tick_s();
      clock_quarter_second = 1'b0;
      chk("freeze.pulse", int'(cap_sp), 0);
      chk("freeze.blink", int'(cap_bl), 0);
      chk_time("freeze", 4, 0, 0);
    end
    btn_inc = 1'b0; step();

    // Reset in REPEAT coincident with tick_q
    set_mode = 2'b01; btn_inc = 1'b1; step();
    chk("rep_press", int'(hours), 5);
    repeat (4) tick_qs();
    chk("rep_enter", int'(hours), 6);
    clock_quarter_second = 1'b1; reset = 1'b0; step();
    chk_time("rep_reset", 0, 0, 0);
    chk("rep_reset.pulse", int'(second_pulse), 0);
    chk("rep_reset.blink", int'(blink), 0);
    clock_quarter_second = 1'b0; btn_inc = 1'b0; reset = 1'b1; step();
    chk("post_reset", int'(hours), 0);
    btn_inc = 1'b1; step();
    chk("post_reset_press", int'(hours), 1);
    btn_inc = 1'b0; step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
